// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, owner codes and
// default parameter values.
package dmem_arbiter_pkg;

  localparam logic [1:0] ARB       = 2'd0;
  localparam logic [1:0] DMA_BURST = 2'd1;
  localparam logic [1:0] CPU_COOL  = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_BURST_MAX = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the DMA has been denied; at_max
// tells the arbiter the DMA must win the next ARB decision.
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_r;

  assign at_max = (cnt_r == MAX_C);

  // clear wins over increment; increment stops at MAX_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !at_max) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage (priority) and a
// DMA engine with starvation-forced grants and bounded locked bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(BURST_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  logic [1:0]    state_r, state_nxt_s;
  logic [BW-1:0] burst_cnt_r, burst_nxt_s;
  logic          owner_s;
  logic          dma_own_s;
  logic          starve_max_s;
  logic          dma_read_s;

  dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (dma_req && !dma_own_s),
    .clr    (!dma_req || dma_own_s),
    .at_max (starve_max_s)
  );

  // ownership decision for the current cycle
  always_comb begin
    owner_s = OWN_CPU;
    case (state_r)
      ARB:       owner_s = (dma_req && (!cpu_req || starve_max_s)) ? OWN_DMA : OWN_CPU;
      DMA_BURST: owner_s = dma_req ? OWN_DMA : OWN_CPU;
      CPU_COOL:  owner_s = (dma_req && !cpu_req) ? OWN_DMA : OWN_CPU;
      default:   owner_s = OWN_CPU;
    endcase
  end

  // reset revokes a DMA grant in the same cycle, even mid-burst
  assign dma_own_s  = (owner_s == OWN_DMA) && !rst;
  assign dma_gnt    = dma_own_s;
  assign cpu_stall  = cpu_req && dma_own_s;
  assign dma_read_s = dma_own_s && !dma_we;

  // burst lock tracking and the one-cycle CPU cool-down after a full burst
  always_comb begin
    state_nxt_s = state_r;
    burst_nxt_s = burst_cnt_r;
    case (state_r)
      ARB: begin
        if (dma_own_s && dma_lock) begin
          state_nxt_s = DMA_BURST;
          burst_nxt_s = BW'(1);
        end else begin
          state_nxt_s = ARB;
          burst_nxt_s = '0;
        end
      end
      DMA_BURST: begin
        if (!dma_req || !dma_lock) begin
          state_nxt_s = ARB;
          burst_nxt_s = '0;
        end else if (burst_cnt_r == BURST_LAST) begin
          state_nxt_s = CPU_COOL;
          burst_nxt_s = '0;
        end else begin
          state_nxt_s = DMA_BURST;
          burst_nxt_s = burst_cnt_r + BW'(1);
        end
      end
      CPU_COOL: begin
        state_nxt_s = ARB;
        burst_nxt_s = '0;
      end
      default: begin
        state_nxt_s = ARB;
        burst_nxt_s = '0;
      end
    endcase
  end

  // memory port mux; an idle port drives zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (dma_own_s) begin
      mem_we    = dma_req && dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_req) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
    end
  end

  // FSM state, burst length and registered DMA read return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ARB;
      burst_cnt_r <= '0;
      dma_rvalid  <= 1'b0;
      dma_rdata   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      burst_cnt_r <= burst_nxt_s;
      dma_rvalid  <= dma_read_s;
      dma_rdata   <= dma_read_s ? mem_rdata : dma_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios, a vector table and
// a randomized run against a behavioural grant model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic        tb_wr = 1'b0;
  logic [7:0]  tb_wa = 8'h0;
  logic [31:0] tb_wd = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory model: combinational read, returns 0 while being written
  assign mem_rdata = mem_we ? 32'h0 : mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cpu_req;
    logic        dma_req;
    logic        exp_gnt;
    logic        exp_stall;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[10];

  // behavioural model state for the random phase
  int  wait_cnt;
  int  burst_grants;
  bit  in_burst, cool;
  bit  eg, rv_exp, rv_n;
  logic [31:0] rd_exp, rd_n;
  int  k;
  bit  exp_g;

  initial begin
    // starvation pattern from a clean ARB state: four CPU grants, then one DMA
    for (int i = 0; i < 10; i++) begin
      tbl[i].cpu_req   = 1'b1;
      tbl[i].dma_req   = 1'b1;
      tbl[i].exp_gnt   = (i == 4) || (i == 9);
      tbl[i].exp_stall = tbl[i].exp_gnt;
      tbl[i].exp_addr  = tbl[i].exp_gnt ? 32'd2 : 32'd1;
    end

    idle();
    rst = 1'b1;
    tb_wr = 1'b1; tb_wa = 8'd6; tb_wd = 32'h4;
    step();
    tb_wa = 8'd15; tb_wd = 32'hA;
    step();
    tb_wr = 1'b0;
    #2;
    chk("reset_gnt", 32'(dma_gnt), 32'h0);
    chk("reset_rvalid", 32'(dma_rvalid), 32'h0);
    chk("reset_rdata", dma_rdata, 32'h0);
    chk("reset_stall", 32'(cpu_stall), 32'h0);
    step();
    rst = 1'b0;

    // CPU-only read
    cpu_req = 1'b1; cpu_addr = 32'd6;
    #2;
    chk("cpu_rd_data", cpu_rdata, 32'h4);
    chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
    chk("cpu_rd_gnt", 32'(dma_gnt), 32'h0);
    chk("cpu_rd_we", 32'(mem_we), 32'h0);
    step();

    // DMA-only read with registered return
    idle();
    dma_req = 1'b1; dma_addr = 32'd15;
    #2;
    chk("dma_rd_gnt", 32'(dma_gnt), 32'h1);
    chk("dma_rd_rvalid0", 32'(dma_rvalid), 32'h0);
    step();
    idle();
    #2;
    chk("dma_rd_rvalid1", 32'(dma_rvalid), 32'h1);
    chk("dma_rd_rdata1", dma_rdata, 32'hA);
    step();
    #2;
    chk("dma_rd_rvalid2", 32'(dma_rvalid), 32'h0);
    chk("dma_rd_hold", dma_rdata, 32'hA);
    step();

    // table: both ports requesting, no lock
    for (int i = 0; i < 10; i++) begin
      idle();
      cpu_req = tbl[i].cpu_req; cpu_addr = 32'd1;
      dma_req = tbl[i].dma_req; dma_addr = 32'd2;
      #2;
      chk($sformatf("tbl%0d_gnt", i), 32'(dma_gnt), 32'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      step();
    end
    idle();
    step();

    // same-address write conflict
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd20; cpu_wdata = 32'h1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd20; dma_wdata = 32'h2;
    #2;
    chk("conf_gnt0", 32'(dma_gnt), 32'h0);
    chk("conf_wdata0", mem_wdata, 32'h1);
    step();
    chk("conf_mem_cpu", mem[20], 32'h1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    chk("conf_gnt1", 32'(dma_gnt), 32'h1);
    chk("conf_wdata1", mem_wdata, 32'h2);
    step();
    chk("conf_mem_dma", mem[20], 32'h2);
    idle();
    step();

    // locked DMA write burst against a busy CPU
    k = 0;
    for (int c = 0; c < 17; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
      dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
      dma_addr = 32'd100 + 32'(k); dma_wdata = 32'(k);
      exp_g = ((c >= 4) && (c <= 11)) || (c == 16);
      #2;
      chk($sformatf("burst%0d_gnt", c), 32'(dma_gnt), 32'(exp_g));
      chk($sformatf("burst%0d_stall", c), 32'(cpu_stall), 32'(exp_g));
      if (exp_g) k++;
      step();
    end
    for (int j = 0; j < 8; j++) chk($sformatf("burst_mem%0d", j), mem[100 + j], 32'(j));
    idle();
    step();
    step();

    // reset in the third cycle of a locked read burst
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'd15;
    #2;
    chk("rstb_gnt0", 32'(dma_gnt), 32'h1);
    step();
    #2;
    chk("rstb_gnt1", 32'(dma_gnt), 32'h1);
    step();
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'd6;
    #2;
    chk("rstb_gnt", 32'(dma_gnt), 32'h0);
    chk("rstb_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rstb_stall", 32'(cpu_stall), 32'h0);
    step();
    rst = 1'b0;
    #2;
    chk("rstb_post_gnt", 32'(dma_gnt), 32'h0);
    chk("rstb_post_stall", 32'(cpu_stall), 32'h0);
    chk("rstb_post_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rstb_post_addr", mem_addr, 32'd6);
    step();

    // randomized run against the grant model
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_cnt = 0; burst_grants = 0; in_burst = 1'b0; cool = 1'b0;
    rv_exp = 1'b0; rd_exp = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      #2;
      if (cool) eg = dma_req && !cpu_req;
      else if (in_burst) eg = dma_req;
      else eg = dma_req && (!cpu_req || (wait_cnt == MAX_WAIT));
      chk("rnd_gnt", 32'(dma_gnt), 32'(eg));
      chk("rnd_stall", 32'(cpu_stall), 32'(cpu_req && eg));
      chk("rnd_mem_we", 32'(mem_we), eg ? 32'(dma_we) : 32'(cpu_req && cpu_we));
      chk("rnd_mem_addr", mem_addr, eg ? dma_addr : (cpu_req ? cpu_addr : 32'h0));
      chk("rnd_mem_wdata", mem_wdata, eg ? dma_wdata : (cpu_req ? cpu_wdata : 32'h0));
      if (cpu_req) chk("rnd_cpu_rdata", cpu_rdata, (eg || cpu_we) ? 32'h0 : mem[cpu_addr[7:0]]);
      chk("rnd_rvalid", 32'(dma_rvalid), 32'(rv_exp));
      chk("rnd_rdata", dma_rdata, rd_exp);
      rv_n = eg && !dma_we;
      rd_n = mem[dma_addr[7:0]];
      if (cool) begin
        cool = 1'b0;
      end else if (in_burst) begin
        if (!dma_req || !dma_lock) begin
          in_burst = 1'b0;
        end else begin
          burst_grants++;
          if (burst_grants == BURST_MAX) begin
            in_burst = 1'b0;
            cool = 1'b1;
          end
        end
      end else if (eg && dma_lock) begin
        in_burst = 1'b1;
        burst_grants = 1;
      end
      wait_cnt = (dma_req && !eg) ? ((wait_cnt < MAX_WAIT) ? wait_cnt + 1 : MAX_WAIT) : 0;
      step();
      rv_exp = rv_n;
      if (rv_n) rd_exp = rd_n;
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 32'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      if (eg || !dma_req) begin
        dma_req = ($urandom_range(0, 3) != 0);
        dma_we = 1'($urandom_range(0, 1));
        dma_lock = ($urandom_range(0, 3) != 0);
        dma_addr = 32'($urandom_range(0, 31));
        dma_wdata = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
